// File: rtl/drawing_priority_n.sv
// N-layer drawing priority mux: the lowest-index enabled, non-transparent drawing layer wins, otherwise the background colour is shown.
// Two-stage pipeline with live and per-frame collision flags. Latency 2 clk; it runs every cycle and never stalls.
module drawing_priority_n #(
  parameter int                 LAYERS     = 4,
  parameter int                 COLOR_W    = 12,
  parameter bit                 TRANSP_EN  = 1'b1,
  parameter logic [COLOR_W-1:0] TRANSP_KEY = 12'h0F0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        pxl_valid,
  input  logic [LAYERS*COLOR_W-1:0]   rgb_in,
  input  logic [LAYERS-1:0]           draw_in,
  input  logic [LAYERS-1:0]           layer_en,
  input  logic [COLOR_W-1:0]          rgb_bg,
  output logic [COLOR_W-1:0]          rgb_out,
  output logic                        out_valid,
  output logic [LAYERS-1:0]           coll_live,
  output logic [LAYERS-1:0]           coll_last,
  output logic                        coll_irq
);

  logic [LAYERS-1:0]         eff_d;
  logic [LAYERS-1:0]         s1_eff;
  logic [LAYERS*COLOR_W-1:0] s1_rgb;
  logic [COLOR_W-1:0]        s1_bg;
  logic                      s1_vld;
  logic                      s1_fs;

  logic [COLOR_W-1:0]        sel_rgb;
  logic [LAYERS-1:0]         live_d;
  logic                      seen;
  logic                      multi;
  logic [LAYERS-1:0]         acc;

  // A layer counts only if it is drawing, enabled, visible and not the colour key.
  always_comb begin
    eff_d = '0;
    for (int i = 0; i < LAYERS; i++) begin
      eff_d[i] = draw_in[i] & layer_en[i] & pxl_valid &
                 ~(TRANSP_EN && (rgb_in[i*COLOR_W +: COLOR_W] == TRANSP_KEY));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_eff <= '0;
      s1_rgb <= '0;
      s1_bg  <= '0;
      s1_vld <= 1'b0;
      s1_fs  <= 1'b0;
    end else begin
      s1_eff <= eff_d;
      s1_rgb <= rgb_in;
      s1_bg  <= rgb_bg;
      s1_vld <= pxl_valid;
      s1_fs  <= frame_start;
    end
  end

  // Scanning from the top index down leaves the lowest active index as the winner.
  always_comb begin
    sel_rgb = s1_bg;
    seen    = 1'b0;
    multi   = 1'b0;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (s1_eff[i]) sel_rgb = s1_rgb[i*COLOR_W +: COLOR_W];
    end
    for (int i = 0; i < LAYERS; i++) begin
      if (s1_eff[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
      end
    end
    live_d = multi ? s1_eff : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out   <= '0;
      out_valid <= 1'b0;
      coll_live <= '0;
      coll_last <= '0;
      coll_irq  <= 1'b0;
      acc       <= '0;
    end else begin
      rgb_out   <= s1_vld ? sel_rgb : '0;
      out_valid <= s1_vld;
      coll_live <= live_d;
      // The frame_start pixel opens the new frame, so it seeds the accumulator.
      if (s1_fs) begin
        coll_last <= acc;
        coll_irq  <= |acc;
        acc       <= live_d;
      end else begin
        coll_irq  <= 1'b0;
        acc       <= acc | live_d;
      end
    end
  end

endmodule

// File: tb/tb_drawing_priority_n.sv
// Bench for drawing_priority_n: a keyed and an unkeyed instance share stimulus and are checked every cycle against a pixel-level model.
module tb_drawing_priority_n;
  localparam int L  = 4;
  localparam int CW = 12;
  localparam logic [CW-1:0] KEY = 12'h0F0;

  typedef struct packed {
    logic [L*CW-1:0] rgb;
    logic [L-1:0]    draw;
    logic [L-1:0]    en;
    logic [CW-1:0]   bg;
    logic            vld;
    logic            fs;
  } rec_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            frame_start = 1'b0;
  logic            pxl_valid = 1'b0;
  logic [L*CW-1:0] rgb_in = '0;
  logic [L-1:0]    draw_in = '0;
  logic [L-1:0]    layer_en = '0;
  logic [CW-1:0]   rgb_bg = '0;

  logic [CW-1:0] rgb_a, rgb_b;
  logic          vld_a, vld_b, irq_a, irq_b;
  logic [L-1:0]  live_a, live_b, last_a, last_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  drawing_priority_n #(.LAYERS(L), .COLOR_W(CW), .TRANSP_EN(1'b1), .TRANSP_KEY(KEY)) dut_a (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pxl_valid(pxl_valid),
    .rgb_in(rgb_in), .draw_in(draw_in), .layer_en(layer_en), .rgb_bg(rgb_bg),
    .rgb_out(rgb_a), .out_valid(vld_a), .coll_live(live_a), .coll_last(last_a), .coll_irq(irq_a));

  drawing_priority_n #(.LAYERS(L), .COLOR_W(CW), .TRANSP_EN(1'b0), .TRANSP_KEY(KEY)) dut_b (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pxl_valid(pxl_valid),
    .rgb_in(rgb_in), .draw_in(draw_in), .layer_en(layer_en), .rgb_bg(rgb_bg),
    .rgb_out(rgb_b), .out_valid(vld_b), .coll_live(live_b), .coll_last(last_b), .coll_irq(irq_b));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Which layers really draw this pixel, from first principles.
  function automatic logic [L-1:0] eff_of(input rec_t r, input bit keyed);
    logic [L-1:0] e;
    e = '0;
    for (int i = 0; i < L; i++)
      e[i] = r.draw[i] && r.en[i] && r.vld && !(keyed && r.rgb[i*CW +: CW] == KEY);
    return e;
  endfunction

  rec_t          held;
  logic [L-1:0]  acc [2];
  logic [CW-1:0] e_rgb [2];
  logic          e_vld [2];
  logic          e_irq [2];
  logic [L-1:0]  e_live [2];
  logic [L-1:0]  e_last [2];

  always @(posedge clk) begin
    rec_t cur;
    cur = '{rgb: rgb_in, draw: draw_in, en: layer_en, bg: rgb_bg, vld: pxl_valid, fs: frame_start};
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        e_rgb[m] = '0; e_vld[m] = 1'b0; e_live[m] = '0; e_last[m] = '0; e_irq[m] = 1'b0; acc[m] = '0;
      end else begin
        logic [L-1:0] e, live;
        int win;
        e = eff_of(held, m == 0);
        win = -1;
        for (int i = L - 1; i >= 0; i--) if (e[i]) win = i;
        if (!held.vld)    e_rgb[m] = '0;
        else if (win < 0) e_rgb[m] = held.bg;
        else              e_rgb[m] = held.rgb[win*CW +: CW];
        e_vld[m] = held.vld;
        live = ($countones(e) >= 2) ? e : '0;
        e_live[m] = live;
        if (held.fs) begin
          e_last[m] = acc[m];
          e_irq[m]  = (acc[m] != '0);
          acc[m]    = live;
        end else begin
          e_irq[m]  = 1'b0;
          acc[m]    = acc[m] | live;
        end
      end
    end
    held = reset ? rec_t'('0) : cur;
    #1;
    chk("a.rgb_out",   32'(rgb_a),  32'(e_rgb[0]));
    chk("a.out_valid", 32'(vld_a),  32'(e_vld[0]));
    chk("a.coll_live", 32'(live_a), 32'(e_live[0]));
    chk("a.coll_last", 32'(last_a), 32'(e_last[0]));
    chk("a.coll_irq",  32'(irq_a),  32'(e_irq[0]));
    chk("b.rgb_out",   32'(rgb_b),  32'(e_rgb[1]));
    chk("b.out_valid", 32'(vld_b),  32'(e_vld[1]));
    chk("b.coll_live", 32'(live_b), 32'(e_live[1]));
    chk("b.coll_last", 32'(last_b), 32'(e_last[1]));
    chk("b.coll_irq",  32'(irq_b),  32'(e_irq[1]));
  end

  task automatic px(input logic [L*CW-1:0] rgb, input logic [L-1:0] draw, input logic [L-1:0] en,
                    input logic [CW-1:0] bg, input bit vld, input bit fs);
    @(negedge clk);
    reset = 1'b0; rgb_in = rgb; draw_in = draw; layer_en = en; rgb_bg = bg;
    pxl_valid = vld; frame_start = fs;
  endtask

  // Two edges after px(); frame_start is dropped after the first so it stays a pulse.
  task automatic wait_out();
    @(posedge clk);
    @(negedge clk);
    frame_start = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic rnd_inputs();
    for (int i = 0; i < L; i++)
      rgb_in[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? KEY : CW'($urandom);
    draw_in   = L'($urandom);
    layer_en  = ($urandom_range(0, 3) == 0) ? L'($urandom) : '1;
    rgb_bg    = CW'($urandom);
    pxl_valid = ($urandom_range(0, 7) != 0);
    frame_start = ($urandom_range(0, 39) == 0);
  endtask

  localparam logic [L*CW-1:0] OVL = {12'h444, 12'h333, 12'h222, 12'h111};

  initial begin
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      reset = 1'b1;
      rnd_inputs();
      @(posedge clk);
      #2;
      chk("pin.reset_rgb", 32'(rgb_a), 32'h0);
      chk("pin.reset_last", 32'(last_a), 32'h0);
    end
    px('0, 4'b0000, 4'hF, 12'hFFF, 1, 0);
    wait_out();
    chk("pin.first_bg", 32'(rgb_a), 32'hFFF);
    chk("pin.first_vld", 32'(vld_a), 32'h1);

    px({12'h456, 12'h777, 12'h123, 12'h999}, 4'b1010, 4'hF, 12'h000, 1, 0);
    wait_out();
    chk("pin.prio_rgb", 32'(rgb_a), 32'h123);
    chk("pin.prio_live", 32'(live_a), 32'hA);

    px({12'h444, 12'h333, 12'h0AB, 12'h0F0}, 4'b0011, 4'b1110, 12'h000, 1, 0);
    wait_out();
    chk("pin.mask_rgb", 32'(rgb_a), 32'h0AB);
    chk("pin.mask_live", 32'(live_a), 32'h0);
    px({12'h444, 12'h333, 12'h0AB, 12'h0F0}, 4'b0011, 4'hF, 12'h000, 1, 0);
    wait_out();
    chk("pin.key_rgb", 32'(rgb_a), 32'h0AB);
    chk("pin.key_live", 32'(live_a), 32'h0);
    chk("pin.nokey_rgb", 32'(rgb_b), 32'h0F0);
    chk("pin.nokey_live", 32'(live_b), 32'h3);

    px(OVL, 4'hF, 4'hF, 12'h000, 1, 0);
    wait_out();
    chk("pin.all_rgb", 32'(rgb_a), 32'h111);
    chk("pin.all_live", 32'(live_a), 32'hF);

    px(OVL, 4'hF, 4'hF, 12'h000, 0, 0);
    wait_out();
    chk("pin.blank_rgb", 32'(rgb_a), 32'h0);
    chk("pin.blank_vld", 32'(vld_a), 32'h0);
    chk("pin.blank_live", 32'(live_a), 32'h0);

    // Frame 1 with a layer 0/2 overlap, then a clean frame 2.
    px(OVL, 4'b0000, 4'hF, 12'h000, 1, 1);
    px(OVL, 4'b0101, 4'hF, 12'h000, 1, 0);
    px(OVL, 4'b0000, 4'hF, 12'h000, 1, 0);
    px(OVL, 4'b0000, 4'hF, 12'h000, 1, 1);
    wait_out();
    chk("pin.f2_last", 32'(last_a), 32'h5);
    chk("pin.f2_irq", 32'(irq_a), 32'h1);
    @(posedge clk);
    #2;
    chk("pin.f2_irq_pulse", 32'(irq_a), 32'h0);
    chk("pin.f2_last_hold", 32'(last_a), 32'h5);
    px(OVL, 4'b0000, 4'hF, 12'h000, 1, 0);
    px(OVL, 4'b0000, 4'hF, 12'h000, 1, 1);
    wait_out();
    chk("pin.f3_last", 32'(last_a), 32'h0);
    chk("pin.f3_irq", 32'(irq_a), 32'h0);

    // Overlap discarded by a mid-frame reset.
    px(OVL, 4'b0000, 4'hF, 12'h000, 1, 1);
    px(OVL, 4'b0011, 4'hF, 12'h000, 1, 0);
    @(negedge clk);
    reset = 1'b1;
    px(OVL, 4'b0000, 4'hF, 12'h000, 1, 0);
    px(OVL, 4'b0000, 4'hF, 12'h000, 1, 1);
    wait_out();
    chk("pin.rst_last", 32'(last_a), 32'h0);
    chk("pin.rst_irq", 32'(irq_a), 32'h0);

    // Back-to-back frame_start with no pixels between them.
    px(OVL, 4'b0101, 4'hF, 12'h000, 1, 0);
    px(OVL, 4'b0000, 4'hF, 12'h000, 0, 1);
    px(OVL, 4'b0000, 4'hF, 12'h000, 0, 1);
    @(posedge clk);
    #2;
    chk("pin.b2b_first", 32'(last_a), 32'h5);
    @(negedge clk);
    frame_start = 1'b0;
    @(posedge clk);
    #2;
    chk("pin.b2b_second", 32'(last_a), 32'h0);
    chk("pin.b2b_irq", 32'(irq_a), 32'h0);

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rnd_inputs();
      reset = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/drawing_priority_n.md
Name: drawing_priority_n

Overview:
- Parametrised N-layer successor to the two-object drawing priority mux. It sits between the object units (sprites, bullets, HUD) and Screens_dispaly.
- Each pixel, it selects the colour of the highest-priority enabled layer that is drawing; otherwise it outputs the background colour.
- Adds a per-layer enable mask, colour-key transparency, live per-layer collision flags, and a per-frame sticky collision snapshot with an event pulse.
- Layer 0 has the highest priority.

Parameters:
LAYERS, 4, number of object layers (2..16)
COLOR_W, 12, bits per RGB pixel, packed {R,G,B}, each COLOR_W/3 bits
TRANSP_EN, 1, 1 = pixels equal to TRANSP_KEY are treated as not drawn
TRANSP_KEY, 12'h0F0, transparent colour key (COLOR_W bits)

Ports:
clk  in  1  pixel clock (clk_25 domain)
reset  in  1  synchronous, active-high
frame_start  in  1  one-cycle pulse coincident with the first pixel of a frame
pxl_valid  in  1  current pixel is in the visible area
rgb_in  in  LAYERS*COLOR_W  layer i colour at bits [i*COLOR_W +: COLOR_W]
draw_in  in  LAYERS  layer i requests draw
layer_en  in  LAYERS  layer i enable mask
rgb_bg  in  COLOR_W  background colour
rgb_out  out  COLOR_W  selected colour
out_valid  out  1  pxl_valid delayed to align with rgb_out
coll_live  out  LAYERS  bit i: layer i overlapped another layer on this output pixel
coll_last  out  LAYERS  sticky OR of coll_live over the previous complete frame
coll_irq  out  1  one-cycle pulse when coll_last is loaded with a non-zero value

Behaviour:
- Reset (sync, high): all pipeline registers clear. rgb_out=0, out_valid=0, coll_live=0, coll_last=0, coll_irq=0, frame accumulator=0.
- Reset takes priority over all other inputs. Reset mid-frame discards the in-flight pixels and the partial accumulator; the first frame_start after reset snapshots an all-zero accumulator (coll_irq stays 0).
- Stage 1 (registered):
  - eff[i] = draw_in[i] & layer_en[i] & pxl_valid & ~(TRANSP_EN & rgb_in[i]==TRANSP_KEY).
  - Register eff, rgb_in, rgb_bg, pxl_valid and frame_start.
- Stage 2 (registered):
  - rgb_out = rgb of the lowest index i with eff[i]=1, else rgb_bg. If the stage-1 pxl_valid is 0, rgb_out=0 (blanking).
  - coll_live[i] = eff[i] & (popcount(eff) >= 2).
  - out_valid = stage-1 pxl_valid.
- Latency: exactly 2 clk from inputs to rgb_out, out_valid and coll_live. This matches RGB_LAT=2 of Screens_dispaly.
- The pipeline runs every cycle. There is no stall or back-pressure.
- Frame accumulator (updated in stage 2, using the stage-2-aligned frame_start):
  - Aligned frame_start=1: coll_last <= acc; acc <= coll_live_next. The pixel carrying frame_start belongs to the new frame. coll_irq <= (acc != 0).
  - Otherwise: acc <= acc | coll_live_next; coll_irq <= 0.
- coll_last holds its value for the whole frame, until the next aligned frame_start.
- Two frame_start pulses with no pixels between them: the second snapshot is all zero.
- Disabled layers (layer_en=0) and keyed-transparent pixels never win arbitration and never contribute to collisions.
- layer_en changes take effect on the pixel presented in the same cycle. No glitch filtering is applied.
- All-layers-drawing case: layer 0 wins, and every coll_live bit is set.

Test Plan:
- Reset then idle: hold reset 3 clk with random inputs -> all outputs 0. Release; first valid pixel with draw_in=0, rgb_bg=12'hFFF -> rgb_out=12'hFFF exactly 2 clk later.
- Priority: LAYERS=4, draw_in=4'b1010, rgb_in layer1=12'h123, layer3=12'h456, layer_en=4'hF -> rgb_out=12'h123; coll_live=4'b1010.
- Mask/transparency: draw_in=4'b0011, layer0 rgb=12'h0F0 (key), layer_en=4'b1110 -> layer0 ignored, layer1 wins, coll_live=0. Repeat with TRANSP_EN=0, layer_en=4'hF -> rgb_out=12'h0F0, coll_live=4'b0011.
- Blanking: pxl_valid=0 with draw_in=4'hF -> rgb_out=0, out_valid=0, coll_live=0.
- Frame snapshot: frame 1 has an overlap of layers 0 and 2 on one pixel; frame 2 is clean.
  - At frame-2 start (+2 clk): coll_last=4'b0101, coll_irq pulses for 1 clk.
  - At frame-3 start: coll_last=0, no coll_irq.
- Reset mid-frame: an overlap occurs, then reset is asserted before frame_start -> next snapshot coll_last=0, coll_irq=0.
